// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential arithmetic blocks (divider today, a
// multiplier later).
//
// Contents:
//   DIV_WIDTH    default operand width
//   div_state_t  control states of the iterative engine: IDLE, CALC, FIX
// -----------------------------------------------------------------------------
package div_pkg;

  // Default operand / result width of the iterative arithmetic blocks.
  localparam int DIV_WIDTH = 32;

  // IDLE : waiting for a request, ready is high
  // CALC : one restoring shift-subtract step per enabled edge
  // FIX  : sign correction and result write-back
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step. The partial remainder is shifted
// left by one, the next dividend bit enters at the bottom, and the divisor is
// trial-subtracted in WIDTH+1 bits. If no borrow results, the difference is
// kept and the quotient bit is 1. Otherwise the shifted value is kept
// (restored) and the quotient bit is 0.
//
// Ports:
//   rem_in        current partial remainder (always < divisor, so WIDTH bits)
//   dividend_bit  next dividend bit, MSB first
//   divisor       divisor magnitude
//   rem_out       updated partial remainder
//   q_bit         quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The shift can carry a 1 into bit WIDTH, so the trial subtraction needs
  // one extra bit. diff[WIDTH] is then the borrow.
  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];

  // Keeping the difference leaves a remainder below the divisor. Restoring
  // keeps the shifted value, which is then also below the divisor. Either
  // way the top bit is zero, so WIDTH bits hold the result.
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule : div_step

// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div
// Iterative restoring divider, signed (DIV) or unsigned (DIVU). Each
// operation takes WIDTH+1 enabled edges from accept to done. The operation
// runs on operand magnitudes, and the signs are applied in a final FIX cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (beats clk_en)
//   clk_en              when low, all state and outputs hold
//   module_en           when low, start_div is ignored
//   start_div           request; sampled only while ready
//   is_signed           1 = two's-complement division, 0 = unsigned
//   operandA, operandB  dividend, divisor (latched on the accept edge)
//   ready               high only in IDLE
//   done                one-cycle pulse when hi/lo/div0 update
//   hi, lo              remainder, quotient
//   div0                last completed operation had a zero divisor
// -----------------------------------------------------------------------------
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH     = DIV_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             module_en,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  // The counter must reach WIDTH-1. One spare bit keeps the post-increment
  // value from wrapping.
  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;

  // quo_reg starts as the dividend magnitude. Each CALC step shifts one
  // dividend bit out of the top and one quotient bit in at the bottom, so
  // after WIDTH steps it holds the unsigned quotient.
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dsr_reg;      // divisor magnitude
  logic [WIDTH-1:0] a_raw_reg;    // dividend as given, returned on divide-by-zero
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             bzero_reg;

  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             div0_reg, done_reg;

  logic             signed_mode;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             take_start;

  // ---------------------------------------------------------------------------
  // Signed path. With SIGNED_EN off, signed mode is tied low, the sign logic
  // folds away, and is_signed has no effect.
  // ---------------------------------------------------------------------------
  generate
    if (SIGNED_EN) begin : g_signed
      assign signed_mode = is_signed;
    end else begin : g_unsigned
      assign signed_mode = 1'b0;
    end
  endgenerate

  assign a_neg = signed_mode & operandA[WIDTH-1];
  assign b_neg = signed_mode & operandB[WIDTH-1];

  // The most-negative value maps to itself here. As an unsigned magnitude
  // it is exactly 2^(WIDTH-1), which is the value the engine needs.
  assign a_mag = a_neg ? ('0 - operandA) : operandA;
  assign b_mag = b_neg ? ('0 - operandB) : operandB;

  assign ready      = (state_reg == ST_IDLE);
  assign take_start = module_en & start_div;

  // ---------------------------------------------------------------------------
  // Single restoring step on the current partial remainder.
  // ---------------------------------------------------------------------------
  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in       (rem_reg),
    .dividend_bit (quo_reg[WIDTH-1]),
    .divisor      (dsr_reg),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // ---------------------------------------------------------------------------
  // Control FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else if (clk_en) begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next-state logic. The register above applies clk_en, so
  // this logic only has to decide what the next enabled edge does.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (take_start) begin
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dsr_reg   <= '0;
      a_raw_reg <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      bzero_reg <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      div0_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (clk_en) begin
      // done is a pulse. Only the FIX edge sets it.
      done_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (take_start) begin
            quo_reg   <= a_mag;
            rem_reg   <= '0;
            dsr_reg   <= b_mag;
            a_raw_reg <= operandA;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
            bzero_reg <= (operandB == '0);
            cnt_reg   <= '0;
          end
        end

        ST_CALC: begin
          quo_reg <= {quo_reg[WIDTH-2:0], step_q};
          rem_reg <= step_rem;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end

        ST_FIX: begin
          done_reg <= 1'b1;
          if (bzero_reg) begin
            // A zero divisor bypasses sign fixup. The engine has already
            // produced an all-ones quotient, but the raw dividend is
            // returned rather than its magnitude.
            lo_reg   <= '1;
            hi_reg   <= a_raw_reg;
            div0_reg <= 1'b1;
          end else begin
            lo_reg   <= neg_q_reg ? ('0 - quo_reg) : quo_reg;
            hi_reg   <= neg_r_reg ? ('0 - rem_reg) : rem_reg;
            div0_reg <= 1'b0;
          end
        end

        default: begin
          cnt_reg <= '0;
        end
      endcase
    end
  end

  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;
  assign div0 = div0_reg;

endmodule : seq_div

// File: tb/tb_seq_div.sv
// -----------------------------------------------------------------------------
// tb_seq_div
// Self-checking bench for seq_div (WIDTH=32, SIGNED_EN=1). It applies known
// vectors, hand-written multi-cycle sequences and random operations. The
// random operations are checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_div;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        module_en;
  logic        start_div;
  logic        is_signed;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        ready;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;

  int vectors;
  int miscompares;

  seq_div #(
    .WIDTH     (32),
    .SIGNED_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .module_en (module_en),
    .start_div (start_div),
    .is_signed (is_signed),
    .operandA  (operandA),
    .operandB  (operandB),
    .ready     (ready),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .div0      (div0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        d0;
  } vec_t;

  vec_t tbl[9];

  // Advance one edge, then settle away from it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Reference model: quotient/remainder straight from integer arithmetic.
  // 64-bit signed division truncates toward zero, the remainder takes the
  // dividend's sign, and -2^31 / -1 is representable before truncation.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] m_lo, output logic [31:0] m_hi, output logic m_d0);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      m_lo = 32'hFFFF_FFFF;
      m_hi = a;
      m_d0 = 1'b1;
    end else if (s) begin
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      q    = sa / sb;
      r    = sa % sb;
      m_lo = q[31:0];
      m_hi = r[31:0];
      m_d0 = 1'b0;
    end else begin
      m_lo = a / b;
      m_hi = a % b;
      m_d0 = 1'b0;
    end
  endtask

  // Wait (bounded) for ready, present the operands and pulse start for one edge.
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int waited);
    waited = 0;
    while (!ready && waited < 100) begin
      step();
      waited++;
    end
    if (!ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: ready=%0b after %0d cycles, expected 1", ready, waited);
    end
    operandA  = a;
    operandB  = b;
    is_signed = s;
    start_div = 1'b1;
    step();
    start_div = 1'b0;
  endtask

  // Count cycles until done. A count that reaches the bound shows up as a
  // latency miscompare.
  task automatic wait_done(input int start_cnt, output int lat);
    lat = start_cnt;
    while (!done && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output int waited);
    accept(a, b, s, waited);
    wait_done(0, lat);
  endtask

  initial begin
    int          lat;
    int          waited;
    int          done_cnt;
    logic [31:0] ra, rb;
    logic        rs;
    logic [31:0] m_lo, m_hi;
    logic        m_d0;

    vectors     = 0;
    miscompares = 0;

    tbl[0] = '{"u_100_div_7",     32'd100,         32'd7,           1'b0, 32'd14,          32'd2,           1'b0};
    tbl[1] = '{"s_m7_div_2",      32'hFFFF_FFF9,   32'd2,           1'b1, 32'hFFFF_FFFD,   32'hFFFF_FFFF,   1'b0};
    tbl[2] = '{"s_7_div_m2",      32'd7,           32'hFFFF_FFFE,   1'b1, 32'hFFFF_FFFD,   32'd1,           1'b0};
    tbl[3] = '{"s_overflow",      32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 32'h8000_0000,   32'd0,           1'b0};
    tbl[4] = '{"u_big_div_max",   32'h8000_0000,   32'hFFFF_FFFF,   1'b0, 32'd0,           32'h8000_0000,   1'b0};
    tbl[5] = '{"u_9_div_3",       32'd9,           32'd3,           1'b0, 32'd3,           32'd0,           1'b0};
    tbl[6] = '{"s_m100_div_m7",   32'hFFFF_FF9C,   32'hFFFF_FFF9,   1'b1, 32'd14,          32'hFFFF_FFFE,   1'b0};
    tbl[7] = '{"s_neg_div_zero",  32'hFFFF_FFF0,   32'd0,           1'b1, 32'hFFFF_FFFF,   32'hFFFF_FFF0,   1'b1};
    tbl[8] = '{"u_1234_div_zero", 32'h0000_1234,   32'd0,           1'b0, 32'hFFFF_FFFF,   32'h0000_1234,   1'b1};

    rst       = 1'b1;
    clk_en    = 1'b1;
    module_en = 1'b1;
    start_div = 1'b0;
    is_signed = 1'b0;
    operandA  = '0;
    operandB  = '0;

    // ---- reset state ----
    step();
    step();
    chk("reset_ready", ready, 1);
    chk("reset_done",  done,  0);
    chk("reset_hi",    hi,    0);
    chk("reset_lo",    lo,    0);
    chk("reset_div0",  div0,  0);
    rst = 1'b0;
    step();

    // ---- known vectors; each follows the previous one back-to-back ----
    for (int i = 0; i < 9; i++) begin
      do_div(tbl[i].a, tbl[i].b, tbl[i].s, lat, waited);
      chk({tbl[i].name, "_lo"},   lo,   tbl[i].lo);
      chk({tbl[i].name, "_hi"},   hi,   tbl[i].hi);
      chk({tbl[i].name, "_div0"}, div0, tbl[i].d0);
      chk({tbl[i].name, "_lat"},  lat,  33);
    end

    // ---- done is a single pulse, results hold afterwards ----
    step();
    chk("done_one_cycle", done, 0);
    chk("hold_lo",        lo,   32'hFFFF_FFFF);
    chk("hold_hi",        hi,   32'h0000_1234);
    chk("hold_div0",      div0, 1);

    // ---- module_en low: start is ignored ----
    module_en = 1'b0;
    operandA  = 32'd50;
    operandB  = 32'd5;
    start_div = 1'b1;
    done_cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) done_cnt++;
    end
    start_div = 1'b0;
    module_en = 1'b1;
    chk("men_low_ready", ready,    1);
    chk("men_low_dones", done_cnt, 0);
    chk("men_low_lo",    lo,       32'hFFFF_FFFF);

    // ---- start pulsed mid-CALC with new operands is ignored ----
    accept(32'd100, 32'd7, 1'b0, waited);
    repeat (4) step();
    operandA  = 32'd5;
    operandB  = 32'd1;
    is_signed = 1'b1;
    start_div = 1'b1;
    step();
    start_div = 1'b0;
    wait_done(5, lat);
    chk("midstart_lo",  lo,  14);
    chk("midstart_hi",  hi,  2);
    chk("midstart_lat", lat, 33);

    // ---- clk_en low for 5 cycles mid-CALC stretches latency to 38 ----
    accept(32'd100, 32'd7, 1'b0, waited);
    repeat (10) step();
    clk_en = 1'b0;
    repeat (5) step();
    clk_en = 1'b1;
    wait_done(15, lat);
    chk("clken_lat", lat, 38);
    chk("clken_lo",  lo,  14);
    chk("clken_hi",  hi,  2);

    // ---- reset in CALC aborts the operation ----
    accept(32'd100, 32'd7, 1'b0, waited);
    repeat (10) step();
    rst = 1'b1;
    step();
    chk("abort_ready", ready, 1);
    chk("abort_done",  done,  0);
    chk("abort_hi",    hi,    0);
    chk("abort_lo",    lo,    0);
    rst      = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    do_div(32'd9, 32'd3, 1'b0, lat, waited);
    chk("after_abort_lo",  lo,  3);
    chk("after_abort_hi",  hi,  0);
    chk("after_abort_lat", lat, 33);

    // ---- back-to-back: ready at done, the next op is accepted without waiting ----
    chk("b2b_ready_at_done", ready, 1);
    do_div(32'd1000, 32'd33, 1'b0, lat, waited);
    chk("b2b_waited", waited, 0);
    chk("b2b_lo",     lo,     30);
    chk("b2b_hi",     hi,     10);

    // ---- randomized operations against the reference model ----
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = 32'd0 - 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, m_lo, m_hi, m_d0);
      do_div(ra, rb, rs, lat, waited);
      chk($sformatf("rnd%0d_lo(%0h/%0h,s=%0b)", i, ra, rb, rs), lo, m_lo);
      chk($sformatf("rnd%0d_hi", i),   hi,   m_hi);
      chk($sformatf("rnd%0d_div0", i), div0, m_d0);
      chk($sformatf("rnd%0d_lat", i),  lat,  33);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_seq_div

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter WIDTH, default 32: operand, quotient and remainder width (>= 4).
REQ-002 Parameter SIGNED_EN, default 1: 1 allows signed mode; 0 ties the signed path off and is_signed is ignored.
REQ-003 clk  input  1  clock; all state changes on the rising edge; one clock domain only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 clk_en  input  1  clock enable; when low, all state, including outputs, holds.
REQ-006 module_en  input  1  block enable; start is ignored while low.
REQ-007 start_div  input  1  request a division; sampled only in IDLE.
REQ-008 is_signed  input  1  1 = two's-complement division (DIV); 0 = unsigned (DIVU).
REQ-009 operandA  input  WIDTH  dividend.
REQ-010 operandB  input  WIDTH  divisor.
REQ-011 ready  output  1  high only in IDLE.
REQ-012 done  output  1  one-cycle pulse when hi/lo/div0 update.
REQ-013 hi  output  WIDTH  remainder.
REQ-014 lo  output  WIDTH  quotient.
REQ-015 div0  output  1  the last completed operation had operandB == 0.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, CALC and FIX.
REQ-017 An accept edge SHALL be a rising edge with clk_en & module_en & start_div & ready; on it the block latches operandA, operandB and is_signed, forms |A| and |B| (magnitudes only in signed mode), clears the iteration counter, and moves to CALC.
REQ-018 CALC SHALL execute one restoring shift-subtract step per enabled edge, MSB first, for exactly WIDTH enabled edges, then move to FIX.
REQ-019 In FIX, the quotient SHALL be negated iff signed mode and the operand signs differ.
REQ-020 In FIX, the remainder SHALL be negated iff signed mode and the dividend is negative.
REQ-021 On the FIX edge, hi, lo and div0 SHALL be written, done SHALL assert for exactly one cycle, and the state SHALL return to IDLE.
REQ-022 Latency SHALL be WIDTH+1 enabled edges from the accept edge to the done edge (33 for WIDTH=32); every low-clk_en cycle adds one cycle.
REQ-023 start_div SHALL be ignored outside IDLE; operand changes after the accept edge SHALL NOT affect the result.
REQ-024 A new start may be accepted on the edge immediately after done (back-to-back operation).
REQ-025 hi, lo and div0 SHALL hold their values until the next done.
REQ-026 Divisor zero: full latency; lo = all ones; hi = operandA unmodified; div0 = 1; no sign fixup.
REQ-027 Signed overflow (A = most-negative, B = -1): lo = most-negative value, hi = 0, div0 = 0; result wraps with no exception.
REQ-028 The identity A = B*lo + hi SHALL hold modulo 2^WIDTH for every B != 0.
REQ-029 Arithmetic inside the datapath SHALL be WIDTH+1 bits wide, so the trial subtraction yields a borrow bit.

Reset
REQ-030 rst high on an enabled or disabled edge SHALL force IDLE, ready=1, done=0, hi=0, lo=0, div0=0, and clear the counter; rst takes priority over clk_en.
REQ-031 Reset during CALC or FIX SHALL abort the operation with no done pulse; the next accepted start behaves normally.

Structure
REQ-032 The state encoding (IDLE/CALC/FIX) and default WIDTH SHALL live in shared package div_pkg, for reuse by a future multiplier.
REQ-033 The single-step restore (shift remainder, trial subtract, set quotient bit) MAY be a combinational sub-module div_step; the block needs no other sub-module.

Verification
REQ-034 Unsigned 100/7, WIDTH=32 -> done 33 cycles after accept; lo=14; hi=2; div0=0.
REQ-035 Signed -7/2 -> lo=0xFFFFFFFD; hi=0xFFFFFFFF. Signed 7/-2 -> lo=0xFFFFFFFD; hi=1.
REQ-036 Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000; hi=0; div0=0. The same operands unsigned -> lo=0; hi=0x80000000.
REQ-037 Divide 0x1234/0 -> lo=0xFFFFFFFF; hi=0x1234; div0=1.
REQ-038 start_div pulsed mid-CALC with new operands -> ignored, and the first result is unchanged. clk_en low for 5 cycles mid-CALC -> done at 38 cycles.
REQ-039 rst asserted at CALC cycle 10 -> next edge gives ready=1, hi=lo=0, and no done pulse. A following 9/3 -> lo=3; hi=0.
